control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Hardwired control unit for the Mini SRC datapath. It replaces the hand-stepped T0..T5 stimulus with a real FSM.
//  It fetches the instruction (T0-T2), decodes IR and issues the per-state execute control word for all
//  register-register ALU, MUL/DIV and NEG/NOT ops. Register select strobes are one-hot vectors sized by NUM_REGS.
//  Adds a run/stop handshake, a memory-ready stall in fetch and an illegal-opcode halt.
// PARAMETERS
//  NUM_REGS   16  general registers; width of Rin/Rout; legal field values 0..NUM_REGS-1
//  IR_W       32  instruction width
//  OP_W       5   opcode width, IR[IR_W-1 -: OP_W]
// PORTS
//  Clock      in   1         system clock, all state changes on posedge
//  Reset_n    in   1         asynchronous, active-low reset
//  Start      in   1         level; IDLE->T0 when high
//  Stop       in   1         level; sampled at instruction boundary
//  Mem_ready  in   1         memory read data valid this cycle
//  IR         in   IR_W      datapath IR register output
//  PCout, Zlowout, Zhighout, MDRout, HIout, LOout       out 1  bus drive strobes
//  PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin       out 1  register load strobes
//  IncPC, Read  out  1        PC+1 through ALU; memory read / MDR source select
//  Rin        out  NUM_REGS  one-hot general register load
//  Rout       out  NUM_REGS  one-hot general register bus drive
//  Alu_op     out  OP_W      opcode forwarded to ALU; 0 when no ALU op is active
//  Busy       out  1         high in any state except IDLE/HALT
//  Illegal    out  1         sticky; set on entry to HALT
// BEHAVIOUR
//  Reset (async, any state): state=IDLE. All outputs are 0, including Rin/Rout/Alu_op/Illegal.
//  Outputs are decoded from state + IR only (Moore), so no strobe glitches across a state change.
//  IR fields: Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15].
//  States:
//   IDLE  nothing asserted; Start -> T0.
//   T0    PCout MARin IncPC Zin -> T1.
//   T1    Zlowout PCin Read MDRin. Held while Mem_ready=0. Repeated PCin reloads the same Z, so it is
//         harmless. Mem_ready=1 -> T2.
//   T2    MDRout IRin -> T3 (IR valid from T3 on).
//   T3    decode. Illegal opcode, or any used field >= NUM_REGS -> HALT. Otherwise:
//         3-reg (ADD 00011, SUB 00100, AND 00101, OR 00110, ROR 00111, ROL 01000, SHR 01001,
//         SHRA 01010, SHL 01011): Rout[Rb] Yin -> T4
//         MUL 01111 / DIV 10000: Rout[Ra] Yin -> T4
//         NEG 10001 / NOT 10010: Rout[Rb] Alu_op Zin -> T4
//   T4    3-reg: Rout[Rc] Alu_op Zin -> T5
//         MUL/DIV: Rout[Rb] Alu_op Zin -> T5
//         NEG/NOT: Zlowout Rin[Ra] -> END
//   T5    3-reg: Zlowout Rin[Ra] -> END
//         MUL/DIV: Zlowout LOin -> T6
//   T6    Zhighout HIin -> END (MUL/DIV only)
//   END   is a transition, not a state. Stop=1 -> IDLE, else -> T0 (back-to-back fetch, no bubble).
//   HALT  Illegal=1; holds until reset. Start/Stop are ignored.
//  Rin/Rout are at most one-hot, and never both nonzero in the same cycle.
//  Exactly one bus driver is active per state; none in IDLE/HALT.
//  Latency (Mem_ready tied 1): 3-reg 6 cycles, MUL/DIV 7, NEG/NOT 5.
//  Stop asserted mid-instruction does not abort it; the instruction completes.
//  Start and Stop both high at END: Stop wins -> IDLE. Start, if still high, restarts next cycle.
//  Ra=Rb=Rc is legal: sequencing is unchanged; Y captures the source before the write-back.
// STRUCTURE
//  minisrc_defs.vh: opcode localparams, state encodings, IR field bit positions.
//  Sub-module minisrc_ir_decode (combinational): IR -> op class {R3,MULDIV,UNARY,ILLEGAL} + Ra/Rb/Rc.
//  control_sequencer: state register, next-state logic, control word decode, one-hot expanders.
// TESTING
//  1 Reset_n=0 during T4 of ADD -> all outputs 0 immediately; after release with Start=0 it stays IDLE.
//  2 Start=1, Mem_ready=1, IR=32'h1A2B8000 (ADD R4,R5,R7) -> T3 Rout=16'h0020 Yin;
//    T4 Rout=16'h0080 Alu_op=5'h03; T5 Rin=16'h0010; then T0 on the next cycle.
//  3 Mem_ready low for 3 cycles in T1 -> T1 lasts 4 cycles, Read/MDRin held, IRin only after Mem_ready=1.
//  4 MUL IR=32'h79980000 (Ra=3, Rb=3) -> T5 LOin, T6 HIin, 7 cycles total, Rin stays 0 throughout.
//  5 IR opcode 11111, or NUM_REGS=8 with Rc=9 -> HALT at T4 slot, Illegal=1, Busy=0, held until reset.
//  6 Stop raised in T2 of NOT (IR=32'h92180000) -> NOT writes Rin[Ra] in T4, then IDLE.
//    Sweep all 13 legal opcodes -> Alu_op matches the opcode in its ALU state.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared constants for the Mini SRC control sequencer: opcodes, FSM states,
// IR field positions and the opcode-class helper.
package control_sequencer_pkg;

   localparam int OPC_W   = 5;
   localparam int FIELD_W = 4;
   localparam int RA_MSB  = 26;
   localparam int RB_MSB  = 22;
   localparam int RC_MSB  = 18;
   localparam int RC_LSB  = RC_MSB - FIELD_W + 1;

   localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
   localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
   localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
   localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
   localparam logic [OPC_W-1:0] OP_ROR  = 5'b00111;
   localparam logic [OPC_W-1:0] OP_ROL  = 5'b01000;
   localparam logic [OPC_W-1:0] OP_SHR  = 5'b01001;
   localparam logic [OPC_W-1:0] OP_SHRA = 5'b01010;
   localparam logic [OPC_W-1:0] OP_SHL  = 5'b01011;
   localparam logic [OPC_W-1:0] OP_MUL  = 5'b01111;
   localparam logic [OPC_W-1:0] OP_DIV  = 5'b10000;
   localparam logic [OPC_W-1:0] OP_NEG  = 5'b10001;
   localparam logic [OPC_W-1:0] OP_NOT  = 5'b10010;

   typedef enum logic [3:0] {
      ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT
   } state_e;

   typedef enum logic [1:0] {
      CLS_R3, CLS_MULDIV, CLS_UNARY, CLS_ILLEGAL
   } op_class_e;

   function automatic op_class_e classify(input logic [OPC_W-1:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
         OP_SHR, OP_SHRA, OP_SHL:  return CLS_R3;
         OP_MUL, OP_DIV:           return CLS_MULDIV;
         OP_NEG, OP_NOT:           return CLS_UNARY;
         default:                  return CLS_ILLEGAL;
      endcase
   endfunction

endpackage

// File: rtl/control_sequencer_ir_decode.sv
// Combinational IR decode: opcode class plus register fields. A register field
// that names a non-existent register demotes the instruction to illegal.
module control_sequencer_ir_decode
   import control_sequencer_pkg::*;
#(
   parameter int NUM_REGS = 16,
   parameter int IR_W     = 32,
   parameter int OP_W     = 5
) (
   input  logic [IR_W-1:0]    ir_i,
   output logic [1:0]         class_o,
   output logic [OP_W-1:0]    opcode_o,
   output logic [FIELD_W-1:0] ra_o,
   output logic [FIELD_W-1:0] rb_o,
   output logic [FIELD_W-1:0] rc_o
);

   op_class_e cls;
   logic      ra_bad, rb_bad, rc_bad;
   logic      unused_low_bits;

   assign opcode_o = ir_i[IR_W-1 -: OP_W];
   assign ra_o     = ir_i[RA_MSB -: FIELD_W];
   assign rb_o     = ir_i[RB_MSB -: FIELD_W];
   assign rc_o     = ir_i[RC_MSB -: FIELD_W];
   assign unused_low_bits = ^ir_i[RC_LSB-1:0];

   assign ra_bad = int'(ra_o) >= NUM_REGS;
   assign rb_bad = int'(rb_o) >= NUM_REGS;
   assign rc_bad = int'(rc_o) >= NUM_REGS;

   // Rc only matters for three-register ops; the others ignore that field.
   always_comb begin
      cls = classify(opcode_o);
      case (cls)
         CLS_R3:              if (ra_bad || rb_bad || rc_bad) cls = CLS_ILLEGAL;
         CLS_MULDIV, CLS_UNARY: if (ra_bad || rb_bad)         cls = CLS_ILLEGAL;
         default: ;
      endcase
   end

   assign class_o = cls;

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Mini SRC control unit: fetch (T0-T2), decode, per-state execute
// control word for ALU, MUL/DIV and NEG/NOT ops. Outputs are pure Moore decode.
module control_sequencer
   import control_sequencer_pkg::*;
#(
   parameter int NUM_REGS = 16,
   parameter int IR_W     = 32,
   parameter int OP_W     = 5
) (
   input  logic                Clock,
   input  logic                Reset_n,
   input  logic                Start,
   input  logic                Stop,
   input  logic                Mem_ready,
   input  logic [IR_W-1:0]     IR,
   output logic                PCout,
   output logic                Zlowout,
   output logic                Zhighout,
   output logic                MDRout,
   output logic                HIout,
   output logic                LOout,
   output logic                PCin,
   output logic                MARin,
   output logic                MDRin,
   output logic                IRin,
   output logic                Yin,
   output logic                Zin,
   output logic                HIin,
   output logic                LOin,
   output logic                IncPC,
   output logic                Read,
   output logic [NUM_REGS-1:0] Rin,
   output logic [NUM_REGS-1:0] Rout,
   output logic [OP_W-1:0]     Alu_op,
   output logic                Busy,
   output logic                Illegal
);

   state_e             state_q, state_d, end_state;
   logic [1:0]         class_bits;
   op_class_e          cls;
   logic [OP_W-1:0]    opcode;
   logic [FIELD_W-1:0] ra, rb, rc;
   logic [FIELD_W-1:0] rin_sel, rout_sel;
   logic               rin_en, rout_en, alu_en;

   control_sequencer_ir_decode #(
      .NUM_REGS (NUM_REGS),
      .IR_W     (IR_W),
      .OP_W     (OP_W)
   ) u_decode (
      .ir_i     (IR),
      .class_o  (class_bits),
      .opcode_o (opcode),
      .ra_o     (ra),
      .rb_o     (rb),
      .rc_o     (rc)
   );

   assign cls = op_class_e'(class_bits);

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Instruction boundary: Stop has priority over starting the next fetch.
   assign end_state = Stop ? ST_IDLE : ST_T0;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (Start) state_d = ST_T0;
         ST_T0:   state_d = ST_T1;
         ST_T1:   if (Mem_ready) state_d = ST_T2;
         ST_T2:   state_d = ST_T3;
         ST_T3:   state_d = (cls == CLS_ILLEGAL) ? ST_HALT : ST_T4;
         ST_T4:   state_d = (cls == CLS_UNARY) ? end_state : ST_T5;
         ST_T5:   state_d = (cls == CLS_MULDIV) ? ST_T6 : end_state;
         ST_T6:   state_d = end_state;
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      {PCout, Zlowout, Zhighout, MDRout, HIout, LOout} = '0;
      {PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, IncPC, Read} = '0;
      rin_en   = 1'b0;
      rin_sel  = ra;
      rout_en  = 1'b0;
      rout_sel = rb;
      alu_en   = 1'b0;
      Busy     = (state_q != ST_IDLE) && (state_q != ST_HALT);
      Illegal  = (state_q == ST_HALT);
      case (state_q)
         ST_T0: begin
            PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
         end
         ST_T1: begin
            Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
         end
         ST_T2: begin
            MDRout = 1'b1; IRin = 1'b1;
         end
         ST_T3: begin
            case (cls)
               CLS_R3:     begin rout_en = 1'b1; rout_sel = rb; Yin = 1'b1; end
               CLS_MULDIV: begin rout_en = 1'b1; rout_sel = ra; Yin = 1'b1; end
               CLS_UNARY:  begin rout_en = 1'b1; rout_sel = rb; alu_en = 1'b1; Zin = 1'b1; end
               default: ;
            endcase
         end
         ST_T4: begin
            case (cls)
               CLS_R3:     begin rout_en = 1'b1; rout_sel = rc; alu_en = 1'b1; Zin = 1'b1; end
               CLS_MULDIV: begin rout_en = 1'b1; rout_sel = rb; alu_en = 1'b1; Zin = 1'b1; end
               CLS_UNARY:  begin Zlowout = 1'b1; rin_en = 1'b1; rin_sel = ra; end
               default: ;
            endcase
         end
         ST_T5: begin
            Zlowout = 1'b1;
            if (cls == CLS_MULDIV) LOin = 1'b1;
            else begin rin_en = 1'b1; rin_sel = ra; end
         end
         ST_T6: begin
            Zhighout = 1'b1; HIin = 1'b1;
         end
         default: ;
      endcase
   end

   assign Alu_op = alu_en ? opcode : '0;

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_onehot
      assign Rin[gi]  = rin_en  && (rin_sel  == FIELD_W'(gi));
      assign Rout[gi] = rout_en && (rout_sel == FIELD_W'(gi));
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: fetch, execute sequences, stalls,
// stop handshake, illegal halts and an opcode sweep.
module tb_control_sequencer;

   logic        Clock = 1'b0;
   logic        Reset_n = 1'b0;
   logic        Start = 1'b0, Stop = 1'b0, Mem_ready = 1'b1, Start8 = 1'b0;
   logic [31:0] IR = '0, IR8 = '0;
   int          errors = 0;
   int          checks = 0;

   logic PCout, Zlowout, Zhighout, MDRout, HIout, LOout, PCin, MARin, MDRin, IRin;
   logic Yin, Zin, HIin, LOin, IncPC, Read, Busy, Illegal;
   logic [15:0] Rin, Rout;
   logic [4:0]  Alu_op;

   logic PCout_8, Zlowout_8, Zhighout_8, MDRout_8, HIout_8, LOout_8, PCin_8, MARin_8, MDRin_8, IRin_8;
   logic Yin_8, Zin_8, HIin_8, LOin_8, IncPC_8, Read_8, Busy_8, Illegal_8;
   logic [7:0]  Rin_8, Rout_8;
   logic [4:0]  Alu_op_8;

   always #5 Clock = ~Clock;

   control_sequencer dut (
      .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .Stop(Stop), .Mem_ready(Mem_ready), .IR(IR),
      .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout), .HIout(HIout), .LOout(LOout),
      .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin),
      .IncPC(IncPC), .Read(Read), .Rin(Rin), .Rout(Rout), .Alu_op(Alu_op), .Busy(Busy), .Illegal(Illegal)
   );

   control_sequencer #(.NUM_REGS(8)) dut8 (
      .Clock(Clock), .Reset_n(Reset_n), .Start(Start8), .Stop(Stop), .Mem_ready(Mem_ready), .IR(IR8),
      .PCout(PCout_8), .Zlowout(Zlowout_8), .Zhighout(Zhighout_8), .MDRout(MDRout_8), .HIout(HIout_8),
      .LOout(LOout_8), .PCin(PCin_8), .MARin(MARin_8), .MDRin(MDRin_8), .IRin(IRin_8), .Yin(Yin_8),
      .Zin(Zin_8), .HIin(HIin_8), .LOin(LOin_8), .IncPC(IncPC_8), .Read(Read_8), .Rin(Rin_8),
      .Rout(Rout_8), .Alu_op(Alu_op_8), .Busy(Busy_8), .Illegal(Illegal_8)
   );

   // Strobe bits, MSB first: PCout Zlowout Zhighout MDRout HIout LOout PCin MARin
   // MDRin IRin Yin Zin HIin LOin IncPC Read Busy Illegal
   localparam logic [17:0] S_PCOUT = 18'h20000, S_ZLOW = 18'h10000, S_ZHIGH = 18'h08000;
   localparam logic [17:0] S_MDROUT = 18'h04000, S_PCIN = 18'h00800, S_MARIN = 18'h00400;
   localparam logic [17:0] S_MDRIN = 18'h00200, S_IRIN = 18'h00100, S_YIN = 18'h00080;
   localparam logic [17:0] S_ZIN = 18'h00040, S_HIIN = 18'h00020, S_LOIN = 18'h00010;
   localparam logic [17:0] S_INCPC = 18'h00008, S_READ = 18'h00004, S_BUSY = 18'h00002, S_ILL = 18'h00001;

   localparam logic [54:0] CW_IDLE = 55'h0;
   localparam logic [54:0] CW_T0 = {S_PCOUT | S_MARIN | S_INCPC | S_ZIN | S_BUSY, 16'h0, 16'h0, 5'h00};
   localparam logic [54:0] CW_T1 = {S_ZLOW | S_PCIN | S_READ | S_MDRIN | S_BUSY, 16'h0, 16'h0, 5'h00};
   localparam logic [54:0] CW_T2 = {S_MDROUT | S_IRIN | S_BUSY, 16'h0, 16'h0, 5'h00};
   localparam logic [54:0] CW_ADD3 = {S_YIN | S_BUSY, 16'h0, 16'h0020, 5'h00};
   localparam logic [54:0] CW_ADD4 = {S_ZIN | S_BUSY, 16'h0, 16'h0080, 5'h03};
   localparam logic [54:0] CW_ADD5 = {S_ZLOW | S_BUSY, 16'h0010, 16'h0, 5'h00};
   localparam logic [54:0] CW_HALT = {S_ILL, 16'h0, 16'h0, 5'h00};

   localparam logic [31:0] IR_ADD = 32'h1A2B8000;   // ADD R4,R5,R7
   localparam logic [31:0] IR_MUL = 32'h79980000;   // MUL Ra=3 Rb=3
   localparam logic [31:0] IR_NOT = 32'h92180000;   // NOT Ra=4 Rb=3

   logic [54:0] snap;
   assign snap = {PCout, Zlowout, Zhighout, MDRout, HIout, LOout, PCin, MARin, MDRin, IRin,
                  Yin, Zin, HIin, LOin, IncPC, Read, Busy, Illegal, Rin, Rout, Alu_op};

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic do_reset();
      Reset_n = 1'b0;
      #2;
      Reset_n = 1'b1;
   endtask

   task automatic test_reset();
      step();
      checks++;
      if ({snap, Busy_8, Illegal_8, Rin_8, Rout_8} !== '0) begin
         $display("FAIL reset_state: got %h expected 0", snap); errors++;
      end
      Reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (snap !== CW_IDLE) begin
            $display("FAIL reset_idle cycle %0d: got %h expected %h", i, snap, CW_IDLE); errors++;
         end
      end
   endtask

   task automatic test_add_back_to_back();
      logic [54:0] exp_a [11];
      exp_a = '{CW_T0, CW_T1, CW_T2, CW_ADD3, CW_ADD4, CW_ADD5,
                CW_T0, CW_T1, CW_T2, CW_ADD3, CW_ADD4};
      IR = IR_ADD; Start = 1'b1; Stop = 1'b0; Mem_ready = 1'b1;
      foreach (exp_a[i]) begin
         step();
         checks++;
         if (snap !== exp_a[i]) begin
            $display("FAIL add_seq cycle %0d: got %h expected %h", i, snap, exp_a[i]); errors++;
         end
      end
   endtask

   task automatic test_async_reset_mid();
      Start = 1'b0;
      #2;
      Reset_n = 1'b0;
      #1;
      checks++;
      if (snap !== CW_IDLE) begin
         $display("FAIL async_reset_T4: got %h expected %h", snap, CW_IDLE); errors++;
      end
      #2;
      Reset_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (snap !== CW_IDLE) begin
            $display("FAIL post_reset_idle cycle %0d: got %h expected %h", i, snap, CW_IDLE); errors++;
         end
      end
   endtask

   task automatic test_mem_stall();
      logic [54:0] exp_a [11];
      exp_a = '{CW_T0, CW_T1, CW_T1, CW_T1, CW_T1, CW_T2, CW_ADD3, CW_ADD4, CW_ADD5, CW_IDLE, CW_IDLE};
      IR = IR_ADD; Start = 1'b1; Stop = 1'b1; Mem_ready = 1'b0;
      foreach (exp_a[i]) begin
         step();
         checks++;
         if (snap !== exp_a[i]) begin
            $display("FAIL mem_stall cycle %0d: got %h expected %h", i, snap, exp_a[i]); errors++;
         end
         if (i == 0) Start = 1'b0;
         if (i == 4) Mem_ready = 1'b1;
      end
   endtask

   task automatic test_mul();
      logic [54:0] exp_a [9];
      exp_a = '{CW_T0, CW_T1, CW_T2,
                {S_YIN | S_BUSY, 16'h0, 16'h0008, 5'h00},
                {S_ZIN | S_BUSY, 16'h0, 16'h0008, 5'h0F},
                {S_ZLOW | S_LOIN | S_BUSY, 16'h0, 16'h0, 5'h00},
                {S_ZHIGH | S_HIIN | S_BUSY, 16'h0, 16'h0, 5'h00},
                CW_IDLE, CW_IDLE};
      IR = IR_MUL; Start = 1'b1; Stop = 1'b1;
      foreach (exp_a[i]) begin
         step();
         checks++;
         if (snap !== exp_a[i]) begin
            $display("FAIL mul_seq cycle %0d: got %h expected %h", i, snap, exp_a[i]); errors++;
         end
         if (i == 0) Start = 1'b0;
      end
   endtask

   task automatic test_not_stop();
      logic [54:0] exp_a [7];
      exp_a = '{CW_T0, CW_T1, CW_T2,
                {S_ZIN | S_BUSY, 16'h0, 16'h0008, 5'h12},
                {S_ZLOW | S_BUSY, 16'h0010, 16'h0, 5'h00},
                CW_IDLE, CW_IDLE};
      IR = IR_NOT; Start = 1'b1; Stop = 1'b0;
      foreach (exp_a[i]) begin
         step();
         checks++;
         if (snap !== exp_a[i]) begin
            $display("FAIL not_stop cycle %0d: got %h expected %h", i, snap, exp_a[i]); errors++;
         end
         if (i == 0) Start = 1'b0;
         if (i == 2) Stop = 1'b1;
      end
   endtask

   task automatic test_opcode_sweep();
      logic [4:0] ops [13];
      int         lat [13];
      logic [4:0] exp_alu;
      ops = '{5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0F, 5'h10, 5'h11, 5'h12};
      lat = '{6, 6, 6, 6, 6, 6, 6, 6, 6, 7, 7, 5, 5};
      // Start and Stop both held high: every END goes to IDLE, then restarts.
      Start = 1'b1; Stop = 1'b1;
      IR = {ops[0], 4'd1, 4'd2, 4'd3, 15'h0};
      step();
      for (int k = 0; k < 13; k++) begin
         IR = {ops[k], 4'd1, 4'd2, 4'd3, 15'h0};
         for (int c = 1; c < lat[k]; c++) begin
            step();
            exp_alu = (c == ((lat[k] == 5) ? 3 : 4)) ? ops[k] : 5'h00;
            checks++;
            if (Alu_op !== exp_alu) begin
               $display("FAIL sweep_alu op %h T%0d: got %h expected %h", ops[k], c, Alu_op, exp_alu); errors++;
            end
         end
         step();
         checks++;
         if (snap !== CW_IDLE) begin
            $display("FAIL sweep_stop op %h: got %h expected %h", ops[k], snap, CW_IDLE); errors++;
         end
         step();
         checks++;
         if (snap !== CW_T0) begin
            $display("FAIL sweep_restart op %h: got %h expected %h", ops[k], snap, CW_T0); errors++;
         end
      end
      Start = 1'b0;
      do_reset();
   endtask

   task automatic test_illegal_opcode();
      logic [54:0] exp_a [9];
      exp_a = '{CW_T0, CW_T1, CW_T2, {S_BUSY, 16'h0, 16'h0, 5'h00},
                CW_HALT, CW_HALT, CW_HALT, CW_HALT, CW_HALT};
      IR = {5'b11111, 4'd1, 4'd2, 4'd3, 15'h0}; Start = 1'b1; Stop = 1'b0;
      foreach (exp_a[i]) begin
         step();
         checks++;
         if (snap !== exp_a[i]) begin
            $display("FAIL illegal_op cycle %0d: got %h expected %h", i, snap, exp_a[i]); errors++;
         end
         if (i == 5) Stop = 1'b1;
         if (i == 6) Start = 1'b0;
      end
      Reset_n = 1'b0;
      #1;
      checks++;
      if (snap !== CW_IDLE) begin
         $display("FAIL illegal_reset: got %h expected %h", snap, CW_IDLE); errors++;
      end
      #1;
      Reset_n = 1'b1;
      Stop = 1'b0;
   endtask

   task automatic test_illegal_field8();
      IR8 = {5'h03, 4'd1, 4'd2, 4'd9, 15'h0}; Start8 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         Start8 = 1'b0;
      end
      checks++;
      if ({Busy_8, Illegal_8} !== 2'b10) begin
         $display("FAIL regs8_T3: got busy/ill %b expected 10", {Busy_8, Illegal_8}); errors++;
      end
      Start8 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({Busy_8, Illegal_8, Rin_8, Rout_8, Alu_op_8, Zin_8} !== {2'b01, 22'h0}) begin
            $display("FAIL regs8_halt cycle %0d: got busy=%b ill=%b rout=%h expected busy=0 ill=1 rout=00",
                     i, Busy_8, Illegal_8, Rout_8); errors++;
         end
      end
      Start8 = 1'b0;
      do_reset();
      // Field 7 is the highest legal register when only eight exist.
      IR8 = {5'h0F, 4'd7, 4'd7, 4'd0, 15'h0}; Start8 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         Start8 = 1'b0;
      end
      checks++;
      if ({Rout_8, Yin_8, Illegal_8} !== {8'h80, 1'b1, 1'b0}) begin
         $display("FAIL regs8_legal_T3: got rout=%h yin=%b ill=%b expected rout=80 yin=1 ill=0",
                  Rout_8, Yin_8, Illegal_8); errors++;
      end
      step();
      checks++;
      if ({Rout_8, Alu_op_8} !== {8'h80, 5'h0F}) begin
         $display("FAIL regs8_legal_T4: got rout=%h alu=%h expected rout=80 alu=0f", Rout_8, Alu_op_8); errors++;
      end
      do_reset();
   endtask

   initial begin
      test_reset();
      test_add_back_to_back();
      test_async_reset_mid();
      test_mem_stall();
      test_mul();
      test_not_stop();
      test_opcode_sweep();
      test_illegal_opcode();
      test_illegal_field8();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
